serial_port: RTL and testbench
==============================

Name: serial_port

Overview:
- Memory-mapped serial transmitter/receiver on the CPU's external device bus.
- Decodes `select_dev`, `address`, `memNotRead`, `memNotWrite`, `csl_n` and `csh_n` from the CPU.
- Drives the shared `data` bus on reads.
- Buffers outgoing bytes in a small FIFO and serialises them 8N1 on `txd`; optionally deserialises `rxd` into a one-byte holding register.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 4..1023.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.
- BASE_ADDR, 15'h0000, device word address; two words used, BASE_ADDR must be even.

Ports:
- clock  in  1  system clock; all state on rising edge.
- notReset  in  1  asynchronous, active-low reset.
- address  in  15  CPU word address.
- data  inout  16  CPU data bus; driven only during a selected read, else high-Z.
- memNotRead  in  1  read strobe, active low.
- memNotWrite  in  1  write strobe, active low.
- csl_n  in  1  low-byte enable, active low.
- csh_n  in  1  high-byte enable, active low.
- select_dev  in  1  high = device space (as opposed to memory).
- txd  out  1  serial out, idle high.
- rxd  in  1  serial in, idle high.
- irq  out  1  high while any enabled interrupt condition holds.

Behaviour:
- Selection: `sel = select_dev & (address[14:1] == BASE_ADDR[14:1])`. Register index is `address[0]`: 0 = DATA, 1 = STATUS/CTRL.
- Read (combinational):
  - While `sel & !memNotRead`, `data` is driven; otherwise `data` is 16'bz.
  - DATA read returns `{8'h00, rx_hold}`.
  - STATUS read returns `{10'b0, ie_tx, ie_rx, rx_ovr, rx_full, tx_empty, tx_full}`.
  - Byte enables are ignored on reads; the full word is always driven.
- Access edge detection:
  - `wr_q` and `rd_q` hold the previous cycle's `sel & !memNotWrite` and `sel & !memNotRead`.
  - An action fires once, on the first clock where the strobe is asserted and the `_q` flag is clear. Multi-cycle strobes act once.
- DATA write, requires `csl_n` = 0:
  - Pushes `data[7:0]` into the TX FIFO.
  - When `tx_full`, the byte is dropped and nothing else changes.
- CTRL write, requires `csl_n` = 0:
  - `ie_rx <= data[4]`, `ie_tx <= data[5]`.
  - `data[3]` = 1 clears `rx_ovr`.
- With `csl_n` = 1, writes have no effect; the high byte is always ignored.
- DATA read: the cycle after the access edge, clears `rx_full`.
- TX FIFO:
  - Circular buffer, wrapping read/write pointers plus a count.
  - A push and a pop in the same cycle leave the count unchanged.
  - `tx_full` = (count == FIFO_DEPTH); `tx_empty` = (count == 0).
- TX state machine:
  - States: IDLE, START, DATA, STOP. A bit counter runs 0..CLKS_PER_BIT-1.
  - IDLE → START when the FIFO is non-empty: pop a byte into the shift register, drive `txd` = 0.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA shifts out LSB first, 8 bits, each lasting CLKS_PER_BIT cycles.
  - STOP holds `txd` = 1 for CLKS_PER_BIT cycles, then returns to IDLE. A queued byte starts in the next cycle (no extra idle bit).
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- irq: `(ie_rx & rx_full) | (ie_tx & tx_empty & tx_state == IDLE)`. Registered output.
- Reset (asynchronous, any time, including mid-frame):
  - TX state IDLE; FIFO pointers and count 0.
  - `txd` = 1, `irq` = 0.
  - `ie_*` = 0, `rx_hold` = 0, `rx_full` = 0, `rx_ovr` = 0.
  - `wr_q` = `rd_q` = 0; RX state IDLE.
  - A partially sent frame is abandoned; the line returns high immediately.

Optional Feature:
- Macro: `SERIAL_PORT_RX_EN`.
- Defined: the RX state machine is built.
  - `rxd` passes through a 2-flop synchroniser.
  - A falling edge in IDLE starts a frame. The start bit is re-sampled at CLKS_PER_BIT/2; if high, the frame is a false start and RX returns to IDLE.
  - 8 data bits are sampled at bit centres, then the stop bit.
  - If the stop bit is 0, it is a framing error: the byte is discarded.
  - Otherwise `rx_hold` is loaded and `rx_full` is set. If `rx_full` was already set, `rx_hold` is overwritten and `rx_ovr` is set.
  - A host clear of `rx_full` in the same cycle as a new byte loading resolves to `rx_full` = 1.
- Undefined: `rxd` is ignored; `rx_hold`, `rx_full`, `rx_ovr` and `ie_rx` read as 0 and never set.

Decomposition:
- Shared package `serial_port_defs`:
  - Register indices `REG_DATA` = 0, `REG_STATUS` = 1.
  - STATUS bit positions.
  - TX/RX state encodings.
- Sub-module: `serial_fifo`, a parameterised synchronous FIFO with push/pop/full/empty/count, instantiated for TX.

Test Plan:
- Reset mid-frame: write 8'hA5, wait 3*CLKS_PER_BIT, pulse notReset low → `txd` = 1 immediately; STATUS reads 16'h0002 (tx_empty); `irq` = 0.
- Single TX: write DATA 8'hA5 → `txd` shows start 0, then 1,0,1,0,0,1,0,1, then stop 1; each bit exactly 16 cycles; 160 cycles total.
- FIFO full and back-to-back: 5 writes (8'h01..8'h05) held for 3 cycles each → the first byte leaves the FIFO immediately, so all 5 are accepted; a 6th write while count = 4 is dropped and STATUS bit0 = 1. Frames are contiguous with no idle gap; only one push per held strobe.
- Byte enable and bus: DATA write with `csl_n` = 1 → no frame. A read with `select_dev` = 0 or address = BASE_ADDR + 2 → `data` stays high-Z.
- irq: write CTRL 16'h0020 (ie_tx) while idle → `irq` = 1. Write a byte → `irq` = 0 until the stop bit ends, then 1.
- RX (macro defined): drive frame 8'h3C on `rxd` → `rx_full` = 1; DATA reads 16'h003C; `rx_full` cleared. Send two frames without reading → `rx_ovr` = 1 and `rx_hold` = second byte. A stop bit of 0 → no load.

Source files
------------

// File: rtl/serial_port_defs.sv
// serial_port_defs: register map, STATUS bit positions and FSM encodings
// shared by the serial_port top and its testbench.
package serial_port_defs;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_IE_RX    = 4;
  localparam int ST_IE_TX    = 5;

  localparam int CTRL_CLR_OVR = 3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/serial_fifo.sv
// serial_fifo: synchronous circular FIFO with wrapping pointers and an
// occupancy count; pushes while full and pops while empty are ignored.
module serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       notReset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/serial_port.sv
// serial_port: memory-mapped 8N1 transmitter with TX FIFO on the CPU device bus.
// The receiver is built only when SERIAL_PORT_RX_EN is defined.
module serial_port
  import serial_port_defs::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [14:0] BASE_ADDR    = 15'h0000
) (
  input  logic        clock,
  input  logic        notReset,
  input  logic [14:0] address,
  inout  wire  [15:0] data,
  input  logic        memNotRead,
  input  logic        memNotWrite,
  input  logic        csl_n,
  input  logic        csh_n,
  input  logic        select_dev,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  logic        sel, rd_act, wr_act, rd_edge, wr_edge;
  logic        wr_q, rd_q;
  logic        tx_push, ctrl_wr;
  logic        ie_tx;
  logic        ie_rx, rx_full, rx_ovr;
  logic [7:0]  rx_hold;
  logic        tx_full, tx_empty, tx_pop;
  logic [7:0]  fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] tx_count;
  logic [15:0] status, rd_word;

  tx_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;

  assign sel     = select_dev & (address[14:1] == BASE_ADDR[14:1]);
  assign rd_act  = sel & ~memNotRead;
  assign wr_act  = sel & ~memNotWrite;
  assign rd_edge = rd_act & ~rd_q;
  assign wr_edge = wr_act & ~wr_q;
  assign tx_push = wr_edge & (address[0] == REG_DATA) & ~csl_n;
  assign ctrl_wr = wr_edge & (address[0] == REG_STATUS) & ~csl_n;

  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_OVR]   = rx_ovr;
    status[ST_IE_RX]    = ie_rx;
    status[ST_IE_TX]    = ie_tx;
    rd_word = (address[0] == REG_DATA) ? {8'h00, rx_hold} : status;
  end

  assign data = rd_act ? rd_word : 16'bz;

  serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock    (clock),
    .notReset (notReset),
    .push     (tx_push),
    .din      (data[7:0]),
    .pop      (tx_pop),
    .dout     (fifo_dout),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  // Popping at the end of STOP chains frames with no idle bit between them.
  assign tx_pop = ~tx_empty &
                  ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & (tx_cnt == BIT_LAST)));

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_shift <= fifo_dout;
            txd      <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_shift <= tx_shift >> 1;
              txd      <= tx_shift[1];
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (!tx_empty) begin
              tx_shift <= fifo_dout;
              txd      <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      ie_tx <= 1'b0;
      irq   <= 1'b0;
    end else begin
      wr_q <= wr_act;
      rd_q <= rd_act;
      if (ctrl_wr) ie_tx <= data[ST_IE_TX];
      irq <= (ie_rx & rx_full) | (ie_tx & tx_empty & (tx_state == TX_IDLE));
    end
  end

`ifdef SERIAL_PORT_RX_EN
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT/2 - 1);

  rx_state_t     rx_state;
  logic [1:0]    rx_sync;
  logic          rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_load;
  logic [7:0]    rx_byte;
  logic          clr_pend;
  logic          rx_s;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      rx_state <= RX_IDLE;
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_load  <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_prev <= rx_s;
      rx_load <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == BIT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s) begin
              rx_load <= 1'b1;
              rx_byte <= rx_shift;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A byte landing in the same cycle as the host clear keeps rx_full set.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      ie_rx    <= 1'b0;
      rx_full  <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_hold  <= '0;
      clr_pend <= 1'b0;
    end else begin
      clr_pend <= rd_edge & (address[0] == REG_DATA);
      if (ctrl_wr) begin
        ie_rx <= data[ST_IE_RX];
        if (data[CTRL_CLR_OVR]) rx_ovr <= 1'b0;
      end
      if (rx_load) begin
        rx_hold <= rx_byte;
        rx_full <= 1'b1;
        if (rx_full) rx_ovr <= 1'b1;
      end else if (clr_pend) begin
        rx_full <= 1'b0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{data[15:8], tx_count, csh_n};
`else
  assign ie_rx   = 1'b0;
  assign rx_full = 1'b0;
  assign rx_ovr  = 1'b0;
  assign rx_hold = 8'h00;

  logic unused_bits;
  assign unused_bits = ^{data[15:8], tx_count, csh_n, rxd, rd_edge};
`endif

endmodule

// File: tb/tb_serial_port.sv
// tb_serial_port: scoreboard bench; stimulus queues expected TX frames and bus
// reads, independent monitors pop and compare as the DUT presents them.
module tb_serial_port;

  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [14:0] BASE  = 15'h0000;

  logic        clock = 1'b0;
  logic        notReset = 1'b0;
  logic [14:0] address = '0;
  logic        memNotRead = 1'b1;
  logic        memNotWrite = 1'b1;
  logic        csl_n = 1'b1;
  logic        csh_n = 1'b1;
  logic        select_dev = 1'b0;
  logic        rxd = 1'b1;
  logic        txd;
  logic        irq;
  logic        drv = 1'b0;
  logic [15:0] drv_val = '0;
  wire  [15:0] data;

  assign data = drv ? drv_val : 16'bz;
  pullup pu_data (data);

  serial_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock       (clock),
    .notReset    (notReset),
    .address     (address),
    .data        (data),
    .memNotRead  (memNotRead),
    .memNotWrite (memNotWrite),
    .csl_n       (csl_n),
    .csh_n       (csh_n),
    .select_dev  (select_dev),
    .txd         (txd),
    .rxd         (rxd),
    .irq         (irq)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  tx_exp_q[$];
  logic [15:0] rd_exp_q[$];
  string       rd_name_q[$];
  int          frame_start[$];
  int          frames_done = 0;
  bit          mon_busy = 1'b0;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus read monitor: every sampled read cycle consumes one expectation.
  initial forever begin
    @(negedge clock);
    if (memNotRead === 1'b0) begin
      if (rd_exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_read: got %h expected no read", data);
      end else begin
        check16(rd_name_q.pop_front(), data, rd_exp_q.pop_front());
      end
    end
  end

  // TX line monitor: compares every cycle of a frame against the ideal waveform.
  initial forever begin
    logic [7:0] e;
    logic [7:0] got;
    logic [9:0] wave;
    int         bad;
    bit         aborted;
    bit         unexp;
    @(negedge clock);
    if (notReset === 1'b1 && txd === 1'b0) begin
      mon_busy = 1'b1;
      frame_start.push_back(cyc);
      unexp = (tx_exp_q.size() == 0);
      e = unexp ? 8'h00 : tx_exp_q.pop_front();
      wave = {1'b1, e, 1'b0};
      bad = 0;
      got = '0;
      aborted = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) @(negedge clock);
        if (notReset !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (txd !== wave[i / CPB]) bad++;
        if ((i % CPB) == CPB / 2 && (i / CPB) >= 1 && (i / CPB) <= 8)
          got[(i / CPB) - 1] = txd;
      end
      if (!aborted) begin
        frames_done++;
        if (unexp) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: got byte %h expected no frame", got);
        end else begin
          check16($sformatf("frame%0d_waveform_errors", frames_done), 16'(bad), 16'h0000);
          check16($sformatf("frame%0d_byte", frames_done), {8'h00, got}, {8'h00, e});
        end
      end
      mon_busy = 1'b0;
    end
  end

  task automatic bus_write(input logic [14:0] a, input logic [15:0] v,
                           input logic lo_n, input int hold);
    @(posedge clock); #1;
    select_dev = 1'b1; address = a; drv = 1'b1; drv_val = v;
    csl_n = lo_n; csh_n = 1'b0; memNotWrite = 1'b0;
    repeat (hold) @(posedge clock);
    #1;
    memNotWrite = 1'b1; drv = 1'b0; select_dev = 1'b0; csl_n = 1'b1; csh_n = 1'b1;
  endtask

  task automatic bus_read(input logic sd, input logic [14:0] a,
                          input logic [15:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    @(posedge clock); #1;
    select_dev = sd; address = a; memNotRead = 1'b0;
    @(posedge clock); #1;
    memNotRead = 1'b1; select_dev = 1'b0;
  endtask

  task automatic wait_tx_idle(input int budget);
    int n = 0;
    while ((tx_exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL tx_timeout: got %0d frames pending expected 0", tx_exp_q.size());
    end
  endtask

`ifdef SERIAL_PORT_RX_EN
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(posedge clock); #1;
    rxd = 1'b0;
    repeat (CPB) @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge clock);
      #1;
    end
    rxd = stop;
    repeat (CPB) @(posedge clock);
    #1;
    rxd = 1'b1;
    repeat (2 * CPB) @(posedge clock);
  endtask
`endif

  initial begin
    int done0;
    int f0;
    int n;

    // Reset state
    repeat (3) @(posedge clock);
    #1 notReset = 1'b1;
    check16("reset_txd", {15'b0, txd}, 16'h0001);
    check16("reset_irq", {15'b0, irq}, 16'h0000);
    bus_read(1'b1, BASE | 15'h1, 16'h0002, "status_after_reset");
    bus_read(1'b1, BASE, 16'h0000, "data_after_reset");

    // Single frame
    tx_exp_q.push_back(8'hA5);
    bus_write(BASE, 16'h00A5, 1'b0, 1);
    wait_tx_idle(FRAME + 50);

    // Five held writes fill the FIFO behind the first frame; a sixth is dropped
    done0 = frames_done;
    f0 = frame_start.size();
    for (int k = 1; k <= 5; k++) tx_exp_q.push_back(8'(k));
    for (int k = 1; k <= 5; k++) bus_write(BASE, {8'hFF, 8'(k)}, 1'b0, 3);
    bus_write(BASE, 16'h0006, 1'b0, 1);
    bus_read(1'b1, BASE | 15'h1, 16'h0001, "status_fifo_full");
    wait_tx_idle(6 * FRAME + 100);
    repeat (2 * FRAME) @(posedge clock);
    check16("burst_frame_count", 16'(frames_done - done0), 16'd5);
    for (int i = f0 + 1; i < f0 + 5 && i < frame_start.size(); i++)
      check16($sformatf("burst_gap_%0d", i - f0), 16'(frame_start[i] - frame_start[i-1]), 16'(FRAME));

    // Byte enable and bus decode
    done0 = frames_done;
    bus_write(BASE, 16'h0055, 1'b1, 1);
    repeat (FRAME + 40) @(posedge clock);
    check16("csl_n_high_no_frame", 16'(frames_done - done0), 16'd0);
    bus_read(1'b1, BASE | 15'h1, 16'h0002, "status_after_csl_write");
    bus_read(1'b0, BASE, 16'hFFFF, "read_unselected_hiz");
    bus_read(1'b1, BASE + 15'd2, 16'hFFFF, "read_other_addr_hiz");

    // irq from TX-empty
    bus_write(BASE | 15'h1, 16'h0020, 1'b0, 1);
    repeat (3) @(posedge clock);
    #1 check16("irq_ie_tx_idle", {15'b0, irq}, 16'h0001);
    bus_read(1'b1, BASE | 15'h1, 16'h0022, "status_ie_tx");
    done0 = frames_done;
    tx_exp_q.push_back(8'h5A);
    bus_write(BASE, 16'h005A, 1'b0, 1);
    repeat (3) @(posedge clock);
    #1 check16("irq_busy", {15'b0, irq}, 16'h0000);
    n = 0;
    while (frames_done == done0 && n < FRAME + 50) begin
      @(posedge clock);
      n++;
    end
    #1 check16("irq_end_of_stop", {15'b0, irq}, 16'h0000);
    @(posedge clock);
    #1 check16("irq_after_frame", {15'b0, irq}, 16'h0001);
    bus_write(BASE | 15'h1, 16'h0000, 1'b0, 1);

    // Reset in the middle of a frame
    tx_exp_q.push_back(8'hA5);
    bus_write(BASE, 16'h00A5, 1'b0, 1);
    repeat (3 * CPB) @(posedge clock);
    #2 notReset = 1'b0;
    #1;
    check16("midframe_reset_txd", {15'b0, txd}, 16'h0001);
    check16("midframe_reset_irq", {15'b0, irq}, 16'h0000);
    repeat (2) @(posedge clock);
    #1 notReset = 1'b1;
    tx_exp_q.delete();
    done0 = frames_done;
    bus_read(1'b1, BASE | 15'h1, 16'h0002, "status_after_midframe_reset");
    repeat (FRAME + 40) @(posedge clock);
    check16("no_frame_after_reset", 16'(frames_done - done0), 16'd0);

`ifdef SERIAL_PORT_RX_EN
    send_rx(8'h3C, 1'b1);
    bus_read(1'b1, BASE | 15'h1, 16'h0006, "status_rx_full");
    bus_read(1'b1, BASE, 16'h003C, "rx_data_3c");
    bus_read(1'b1, BASE | 15'h1, 16'h0002, "status_rx_cleared");
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_read(1'b1, BASE | 15'h1, 16'h000E, "status_rx_overrun");
    bus_read(1'b1, BASE, 16'h0022, "rx_data_second");
    bus_write(BASE | 15'h1, 16'h0008, 1'b0, 1);
    bus_read(1'b1, BASE | 15'h1, 16'h0002, "status_ovr_cleared");
    send_rx(8'h77, 1'b0);
    bus_read(1'b1, BASE | 15'h1, 16'h0002, "status_framing_error");
    bus_read(1'b1, BASE, 16'h0022, "rx_data_kept");
`endif

    repeat (4) @(posedge clock);
    check16("reads_all_observed", 16'(rd_exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
